sfx_scheduler: RTL and testbench

- Sequences the shared tone generator and volume path between up to NUM_REQ sound-effect requesters (e.g. food eaten, level up, collision, game over).
- Latches request pulses and grants the generator by strict priority, with preemption.
- Steps through a short fixed note sequence per effect and gates the user volume word onto the amplitude output.
- Sits between the game FSM and the tone generator; volume comes from the volume control block.

---
 rtl/sfx_pkg.sv | 38 +++
 rtl/sfx_tick_gen.sv | 32 +++
 rtl/sfx_scheduler.sv | 148 ++++++++++++++
 tb/tb_sfx_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect scheduler: note codes, FSM states and the effect note table.
// Pure constants and a combinational table lookup; no latency and no flow control.
package sfx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } sfx_state_e;

    // Semitone index starting at C4 = 1; 0 is a rest.
    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_C4   = 5'd1;
    localparam logic [4:0] NOTE_D4   = 5'd3;
    localparam logic [4:0] NOTE_E4   = 5'd5;
    localparam logic [4:0] NOTE_FS4  = 5'd7;
    localparam logic [4:0] NOTE_GS4  = 5'd9;
    localparam logic [4:0] NOTE_B4   = 5'd12;

    localparam int SFX_IDS = 4;
    localparam int SFX_LEN = 4;

    localparam logic [4:0] SFX_ROM [SFX_IDS][SFX_LEN] = '{
        '{NOTE_E4,  NOTE_FS4,  NOTE_GS4, NOTE_B4  },
        '{NOTE_B4,  NOTE_REST, NOTE_B4,  NOTE_REST},
        '{NOTE_GS4, NOTE_FS4,  NOTE_E4,  NOTE_D4  },
        '{NOTE_C4,  NOTE_C4,   NOTE_C4,  NOTE_C4  }
    };

    // Ids or steps outside the table play as a rest.
    function automatic logic [4:0] sfx_note(input logic [4:0] id, input logic [4:0] step);
        sfx_note = NOTE_REST;
        if (id < 5'(SFX_IDS) && step < 5'(SFX_LEN)) begin
            sfx_note = SFX_ROM[id[1:0]][step[1:0]];
        end
    endfunction

endpackage

// File: rtl/sfx_tick_gen.sv
// Timing-tick divider: tick is high in the last cycle of every TICK_DIV-cycle period.
// clr restarts the period at the next edge; no backpressure.
module sfx_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Strict-priority, preempting sequencer of sound effects onto one tone generator and volume path.
// Grant follows a latched request by one edge; outputs are registered except amplitude; no backpressure.
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TICK_DIV      = 1000000,
    parameter int NOTE_TICKS    = 10,
    parameter int NOTES_PER_SFX = 4,
    parameter int GAP_TICKS     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [15:0]        volume_in,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [4:0]         note_code,
    output logic [15:0]        amplitude,
    output logic               done
);
    localparam int CW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW      = (NOTES_PER_SFX > 1) ? $clog2(NOTES_PER_SFX) : 1;
    localparam int CNT_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int NW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    sfx_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [CW-1:0]      cur_q, cur_d;
    logic [SW-1:0]      step_q, step_d;
    logic [NW-1:0]      nt_q, nt_d;
    logic               done_q, done_d;
    logic               tick, tick_clr, start;
    logic [NUM_REQ-1:0] higher, start_vec, clr_mask;

    function automatic logic [CW-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = CW'(i);
        end
    endfunction

    sfx_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            higher[i] = pending_q[i] && (CW'(i) < cur_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        step_d    = step_q;
        nt_d      = nt_q;
        done_d    = 1'b0;
        tick_clr  = 1'b0;
        start     = 1'b0;
        start_vec = '0;
        clr_mask  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    start     = 1'b1;
                    start_vec = pending_q;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (|higher) begin
                        start     = 1'b1;
                        start_vec = higher;
                    end else if (nt_q == NW'(NOTE_TICKS - 1)) begin
                        nt_d = '0;
                        if (step_q == SW'(NOTES_PER_SFX - 1)) begin
                            state_d  = ST_GAP;
                            step_d   = '0;
                            done_d   = 1'b1;
                            tick_clr = 1'b1;
                        end else begin
                            step_d = step_q + SW'(1);
                        end
                    end else begin
                        nt_d = nt_q + NW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (nt_q == NW'(GAP_TICKS - 1)) begin
                        state_d = ST_IDLE;
                        nt_d    = '0;
                    end else begin
                        nt_d = nt_q + NW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Preemption and the idle grant share one restart path.
        if (start) begin
            state_d  = ST_PLAY;
            cur_d    = lowest_idx(start_vec);
            step_d   = '0;
            nt_d     = '0;
            tick_clr = 1'b1;
            clr_mask[cur_d] = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | req;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            cur_q     <= '0;
            step_q    <= '0;
            nt_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_q     <= cur_d;
            step_q    <= step_d;
            nt_q      <= nt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        grant     = '0;
        note_code = NOTE_REST;
        if (state_q == ST_PLAY) begin
            grant[cur_q] = 1'b1;
            note_code    = sfx_note(5'(cur_q), 5'(step_q));
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign amplitude = (note_code != NOTE_REST) ? volume_in : 16'h0000;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scoreboarded bench: a time-based reference model predicts every cycle's outputs, a monitor compares them.
module tb_sfx_scheduler;
    localparam int NR = 4;
    localparam int TD = 4;
    localparam int NT = 2;
    localparam int NP = 4;
    localparam int GT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [15:0]   volume_in;
    logic [NR-1:0] grant;
    logic          busy;
    logic [4:0]    note_code;
    logic [15:0]   amplitude;
    logic          done;

    always #5 clk = ~clk;

    sfx_scheduler #(
        .NUM_REQ       (NR),
        .TICK_DIV      (TD),
        .NOTE_TICKS    (NT),
        .NOTES_PER_SFX (NP),
        .GAP_TICKS     (GT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .volume_in (volume_in),
        .grant     (grant),
        .busy      (busy),
        .note_code (note_code),
        .amplitude (amplitude),
        .done      (done)
    );

    typedef struct packed {
        logic [NR-1:0] grant;
        logic          busy;
        logic [4:0]    note;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rom [4][4] = '{'{5, 7, 9, 12}, '{12, 0, 12, 0}, '{9, 7, 5, 3}, '{1, 1, 1, 1}};

    // Model state: mode 0 idle, 1 playing, 2 gap; m_t counts cycles since the effect started.
    int        m_mode = 0;
    int        m_cur  = 0;
    int        m_t    = 0;
    int        m_g    = 0;
    logic [3:0] m_pend = '0;

    function automatic int lowest_below(input logic [3:0] p, input int lim);
        for (int j = 0; j < lim; j++) begin
            if (p[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin : model
        exp_t e;
        int   hi;
        logic fin;
        fin = 1'b0;
        if (!rst_n) begin
            m_mode = 0;
            m_pend = '0;
            m_cur  = 0;
            m_t    = 0;
            m_g    = 0;
        end else begin
            hi = -1;
            if (m_mode == 0) begin
                hi = lowest_below(m_pend, NR);
            end else if (m_mode == 1) begin
                if (m_t % TD == TD - 1) hi = lowest_below(m_pend, m_cur);
                if (hi < 0) begin
                    if (m_t == NT * NP * TD - 1) begin
                        m_mode = 2;
                        m_g    = 0;
                        fin    = 1'b1;
                    end else begin
                        m_t++;
                    end
                end
            end else begin
                if (m_g == GT * TD - 1) m_mode = 0;
                else m_g++;
            end
            if (hi >= 0) begin
                m_pend[hi] = 1'b0;
                m_cur      = hi;
                m_t        = 0;
                m_mode     = 1;
            end
            m_pend = m_pend | req;
        end
        e.grant = (m_mode == 1) ? NR'(1 << m_cur) : '0;
        e.busy  = (m_mode != 0);
        e.note  = (m_mode == 1) ? 5'(rom[m_cur][m_t / (TD * NT)]) : 5'd0;
        e.done  = fin;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant",     16'(grant),     16'(e.grant));
            chk("busy",      16'(busy),      16'(e.busy));
            chk("note_code", 16'(note_code), 16'(e.note));
            chk("done",      16'(done),      16'(e.done));
            chk("amplitude", amplitude, (e.note != 5'd0) ? volume_in : 16'h0000);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NR-1:0] m, input int len);
        @(posedge clk);
        #1 req = m;
        repeat (len) @(posedge clk);
        #1 req = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        volume_in = 16'h2000;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Basic effect, then preemption of id2 by id0 during its second note.
        pulse(4'b0010, 1);
        cycles(50);
        pulse(4'b0100, 1);
        cycles(12);
        pulse(4'b0001, 1);
        cycles(60);

        // Simultaneous requests, then a re-request coinciding with its own grant.
        pulse(4'b1100, 1);
        cycles(100);
        pulse(4'b0010, 2);
        cycles(100);

        // Muted volume still sequences and completes.
        volume_in = 16'h0000;
        pulse(4'b0001, 1);
        cycles(50);
        volume_in = 16'h2000;

        // Reset mid-note with a pending request; a low glitch between edges must be ignored.
        pulse(4'b0100, 1);
        cycles(6);
        pulse(4'b1000, 1);
        cycles(3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(4);
        pulse(4'b0010, 1);
        cycles(3);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        cycles(50);

        // Randomized traffic with volume changes and rare resets.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            req = ($urandom_range(0, 9) == 0) ? NR'($urandom_range(1, 15)) : '0;
            if ($urandom_range(0, 19) == 0) volume_in = 16'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
        end
        #1 req = '0;
        rst_n = 1'b1;
        cycles(120);

        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
